// File: rtl/seg_page_ctrl_pkg.sv
// seg_page_ctrl_pkg
//   Shared definitions for the display page scheduler:
//   - glyph codes understood by the 6-digit dynamic-scan driver
//   - controller FSM state encoding
//   - the BCD reading record kept in the shadow registers
//   - number of shift/add-3 steps of the 8-bit double-dabble converter
package seg_page_ctrl_pkg;

  // Glyph codes: 0-9 plain digit, 10-19 digit with decimal point.
  localparam logic [4:0] SEG_DASH   = 5'd20;
  localparam logic [4:0] SEG_C      = 5'd21;
  localparam logic [4:0] SEG_H      = 5'd22;
  localparam logic [4:0] SEG_BLANK  = 5'd31;
  localparam logic [4:0] SEG_PT_OFS = 5'd10;

  // One load cycle followed by this many shift cycles per byte.
  localparam logic [3:0] BCD_SHIFTS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // One displayed quantity: integer byte as hundreds/tens/ones, and the
  // ones digit of the decimal byte.
  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
    logic [3:0] dec;
  } reading_t;

  function automatic logic [4:0] digit_glyph(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_8.sv
// bin2bcd_8
//   Sequential double-dabble converter for one byte. A start pulse loads
//   bin; the following 8 cycles shift with add-3 correction, so results are
//   valid (done = 1) 9 cycles after start and hold until the next start.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load bin and begin a conversion
//   bin[7:0]       binary input, sampled on start
//   done           1 once the 8 shift steps have completed
//   hun/ten/one    BCD digits of the converted byte
import seg_page_ctrl_pkg::*;

module bin2bcd_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hun,
  output logic [3:0] ten,
  output logic [3:0] one
);

  // {hun, ten, one, remaining binary bits}
  logic [19:0] sr_reg;
  logic [19:0] sr_adj;
  logic [3:0]  cnt_reg;
  logic        done_reg;

  // Add-3 correction on every BCD nibble that is >= 5 before shifting.
  assign sr_adj[7:0] = sr_reg[7:0];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign sr_adj[8+4*gi +: 4] = (sr_reg[8+4*gi +: 4] >= 4'd5) ?
                                   sr_reg[8+4*gi +: 4] + 4'd3 :
                                   sr_reg[8+4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (start) begin
      sr_reg   <= {12'd0, bin};
      cnt_reg  <= BCD_SHIFTS;
      done_reg <= 1'b0;
    end else if (cnt_reg != 4'd0) begin
      sr_reg   <= {sr_adj[18:0], 1'b0};
      cnt_reg  <= cnt_reg - 4'd1;
      done_reg <= (cnt_reg == 4'd1);
    end
  end

  assign done = done_reg;
  assign hun  = sr_reg[19:16];
  assign ten  = sr_reg[15:12];
  assign one  = sr_reg[11:8];

endmodule

// File: rtl/seg_page_ctrl.sv
// seg_page_ctrl
//   Display scheduler between the DHT11 reader and the 6-digit scan driver.
//   A valid sample is latched, its four bytes are converted to BCD one after
//   another (36 cycles), and the results are committed atomically to shadow
//   registers. A free-running timer alternates a temperature page and a
//   humidity page; dis1..dis6 are re-registered every cycle from the shadow
//   registers, the page bit and the error state.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   data_valid, data_err    1-cycle pulses from the sensor reader
//   hum_int/hum_dec         humidity integer / decimal byte
//   tem_int/tem_dec         temperature integer / decimal byte
//   busy                    1 while a sample is converting or committing
//   page                    0 = temperature page, 1 = humidity page
//   dis1..dis6              glyph codes, dis1 leftmost
// Parameters:
//   CNT_MAX_PAGE            clock cycles per page (>= 2)
// Build option:
//   SEG_LZ_BLANK_EN         when defined, a leading tens digit of 0 is blanked
import seg_page_ctrl_pkg::*;

module seg_page_ctrl #(
  parameter logic [27:0] CNT_MAX_PAGE = 28'd150_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_valid,
  input  logic       data_err,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tem_int,
  input  logic [7:0] tem_dec,
  output logic       busy,
  output logic       page,
  output logic [4:0] dis1,
  output logic [4:0] dis2,
  output logic [4:0] dis3,
  output logic [4:0] dis4,
  output logic [4:0] dis5,
  output logic [4:0] dis6
);

  state_t      state_reg;
  logic [1:0]  byte_idx_reg;
  logic [3:0]  phase_reg;
  logic        busy_reg;
  logic        err_flag_reg;
  logic        valid_seen_reg;

  logic [7:0]  tem_int_reg;
  logic [7:0]  tem_dec_reg;
  logic [7:0]  hum_int_reg;
  logic [7:0]  hum_dec_reg;

  // Staging for finished conversions; shadows only change in COMMIT.
  reading_t    tem_stage_reg;
  logic [11:0] hum_int_bcd_reg;
  reading_t    tem_shadow_reg;
  reading_t    hum_shadow_reg;

  logic [27:0] page_cnt_reg;
  logic        page_reg;

  logic [4:0]  dis_reg  [6];
  logic [4:0]  dis_next [6];
  reading_t    sel;
  logic [4:0]  tens_glyph;

  logic        bcd_start;
  logic [7:0]  bcd_bin;
  logic        bcd_done;
  logic [3:0]  bcd_hun;
  logic [3:0]  bcd_ten;
  logic [3:0]  bcd_one;

  // Each byte occupies a 9-cycle slot; phase 0 of the slot is the load.
  assign bcd_start = (state_reg == ST_CONV) && (phase_reg == 4'd0);

  always_comb begin
    bcd_bin = hum_dec_reg;
    case (byte_idx_reg)
      2'd0:    bcd_bin = tem_int_reg;
      2'd1:    bcd_bin = tem_dec_reg;
      2'd2:    bcd_bin = hum_int_reg;
      default: bcd_bin = hum_dec_reg;
    endcase
  end

  bin2bcd_8 u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   (bcd_bin),
    .done  (bcd_done),
    .hun   (bcd_hun),
    .ten   (bcd_ten),
    .one   (bcd_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      byte_idx_reg    <= '0;
      phase_reg       <= '0;
      busy_reg        <= 1'b0;
      err_flag_reg    <= 1'b0;
      valid_seen_reg  <= 1'b0;
      tem_int_reg     <= '0;
      tem_dec_reg     <= '0;
      hum_int_reg     <= '0;
      hum_dec_reg     <= '0;
      tem_stage_reg   <= '0;
      hum_int_bcd_reg <= '0;
      tem_shadow_reg  <= '0;
      hum_shadow_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // An error in the same cycle as a sample discards the sample.
          if (data_err) begin
            err_flag_reg <= 1'b1;
          end else if (data_valid) begin
            tem_int_reg  <= tem_int;
            tem_dec_reg  <= tem_dec;
            hum_int_reg  <= hum_int;
            hum_dec_reg  <= hum_dec;
            byte_idx_reg <= 2'd0;
            phase_reg    <= 4'd0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (data_err) err_flag_reg <= 1'b1;
          // At the load of byte k the converter still holds byte k-1.
          if (phase_reg == 4'd0 && bcd_done) begin
            case (byte_idx_reg)
              2'd1: begin
                tem_stage_reg.hun <= bcd_hun;
                tem_stage_reg.ten <= bcd_ten;
                tem_stage_reg.one <= bcd_one;
              end
              2'd2:    tem_stage_reg.dec <= bcd_one;
              2'd3:    hum_int_bcd_reg   <= {bcd_hun, bcd_ten, bcd_one};
              default: ;
            endcase
          end
          if (phase_reg == BCD_SHIFTS) begin
            phase_reg <= 4'd0;
            if (byte_idx_reg == 2'd3) state_reg <= ST_COMMIT;
            else byte_idx_reg <= byte_idx_reg + 2'd1;
          end else begin
            phase_reg <= phase_reg + 4'd1;
          end
        end
        ST_COMMIT: begin
          // The last byte (humidity decimal) is taken straight from the
          // converter so all eight digits update in the same cycle.
          tem_shadow_reg <= tem_stage_reg;
          hum_shadow_reg <= {hum_int_bcd_reg, bcd_one};
          valid_seen_reg <= 1'b1;
          err_flag_reg   <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Page timer runs independently of the FSM and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_cnt_reg <= '0;
      page_reg     <= 1'b0;
    end else if (page_cnt_reg == CNT_MAX_PAGE - 28'd1) begin
      page_cnt_reg <= '0;
      page_reg     <= ~page_reg;
    end else begin
      page_cnt_reg <= page_cnt_reg + 28'd1;
    end
  end

  always_comb begin
    sel        = page_reg ? hum_shadow_reg : tem_shadow_reg;
    tens_glyph = digit_glyph(sel.ten);
`ifdef SEG_LZ_BLANK_EN
    if (sel.ten == 4'd0) tens_glyph = SEG_BLANK;
`else
    tens_glyph = digit_glyph(sel.ten);
`endif
    for (int i = 0; i < 6; i++) dis_next[i] = SEG_DASH;
    if (!err_flag_reg && valid_seen_reg) begin
      // A non-zero hundreds digit means the value does not fit in XY.
      if (sel.hun != 4'd0) begin
        dis_next[0] = SEG_DASH;
        dis_next[1] = SEG_DASH;
      end else begin
        dis_next[0] = tens_glyph;
        dis_next[1] = digit_glyph(sel.one) + SEG_PT_OFS;
      end
      dis_next[2] = digit_glyph(sel.dec);
      dis_next[3] = SEG_BLANK;
      dis_next[4] = SEG_BLANK;
      dis_next[5] = page_reg ? SEG_H : SEG_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) dis_reg[i] <= SEG_DASH;
    end else begin
      for (int i = 0; i < 6; i++) dis_reg[i] <= dis_next[i];
    end
  end

  assign busy = busy_reg;
  assign page = page_reg;
  assign dis1 = dis_reg[0];
  assign dis2 = dis_reg[1];
  assign dis3 = dis_reg[2];
  assign dis4 = dis_reg[3];
  assign dis5 = dis_reg[4];
  assign dis6 = dis_reg[5];

endmodule

// File: tb/tb_seg_page_ctrl.sv
// tb_seg_page_ctrl
//   Scoreboard bench for seg_page_ctrl with a 100-cycle page. Stimulus
//   tasks queue expected (cycle, kind, value) entries; a monitor on the
//   falling edge pops every entry due at the current cycle and compares.
//   Cycle k means "after rising edge k", counted from the last reset release.
`timescale 1ns/1ps

module tb_seg_page_ctrl;

  localparam logic [1:0] K_DIS  = 2'd0;
  localparam logic [1:0] K_PAGE = 2'd1;
  localparam logic [1:0] K_BUSY = 2'd2;

  typedef struct packed {
    int          at;
    logic [1:0]  kind;
    logic [29:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_err = 1'b0;
  logic [7:0] hum_int = '0;
  logic [7:0] hum_dec = '0;
  logic [7:0] tem_int = '0;
  logic [7:0] tem_dec = '0;
  logic       busy;
  logic       page;
  logic [4:0] dis1, dis2, dis3, dis4, dis5, dis6;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];

  seg_page_ctrl #(.CNT_MAX_PAGE(28'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_err   (data_err),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .tem_int    (tem_int),
    .tem_dec    (tem_dec),
    .busy       (busy),
    .page       (page),
    .dis1       (dis1),
    .dis2       (dis2),
    .dis3       (dis3),
    .dis4       (dis4),
    .dis5       (dis5),
    .dis6       (dis6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] pk(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
    logic [4:0] va, vb, vc, vd, ve, vf;
    va = a[4:0]; vb = b[4:0]; vc = c[4:0];
    vd = d[4:0]; ve = e[4:0]; vf = f[4:0];
    return {va, vb, vc, vd, ve, vf};
  endfunction

  function automatic string fmt(input logic [1:0] k, input logic [29:0] v);
    if (k == K_DIS)
      return $sformatf("%0d,%0d,%0d,%0d,%0d,%0d",
                       v[29:25], v[24:20], v[19:15], v[14:10], v[9:5], v[4:0]);
    return $sformatf("%0d", v[0]);
  endfunction

  // Sorted insert so tests may queue expectations out of cycle order.
  task automatic push(input int j, input logic [1:0] kind,
                      input logic [29:0] val, input string nm);
    exp_t e;
    int   pos;
    e.at = base + j;
    e.kind = kind;
    e.val = val;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].at > e.at) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
    name_q.insert(pos, nm);
  endtask

  task automatic exp_dis(input int j, input logic [29:0] v, input string nm);
    push(j, K_DIS, v, nm);
  endtask

  task automatic exp_bit(input int j, input logic [1:0] k, input logic b,
                         input string nm);
    push(j, k, {29'd0, b}, nm);
  endtask

  // Drive one pulse so it is sampled by rising edge j.
  task automatic send(input int j, input int ti, input int td, input int hi,
                      input int hd, input logic v, input logic er);
    while (cyc < base + j - 1) @(negedge clk);
    tem_int = ti[7:0]; tem_dec = td[7:0];
    hum_int = hi[7:0]; hum_dec = hd[7:0];
    data_valid = v;
    data_err = er;
    $display("txn cyc=%0d valid=%0d err=%0d tem=%0d.%0d hum=%0d.%0d",
             j, v, er, ti, td, hi, hd);
    @(negedge clk);
    data_valid = 1'b0;
    data_err = 1'b0;
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  exp_t        m_e;
  string       m_nm;
  logic [29:0] m_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      m_e = exp_q.pop_front();
      m_nm = name_q.pop_front();
      case (m_e.kind)
        K_DIS:   m_act = {dis1, dis2, dis3, dis4, dis5, dis6};
        K_PAGE:  m_act = {29'd0, page};
        default: m_act = {29'd0, busy};
      endcase
      checks++;
      if (m_e.at != cyc) begin
        errors++;
        $display("FAIL %s late: due cyc %0d, checked at %0d", m_nm, m_e.at, cyc);
      end else if (m_act !== m_e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %s want %s", m_nm, cyc - base,
                 fmt(m_e.kind, m_act), fmt(m_e.kind, m_e.val));
      end
    end
  end

  logic [29:0] dash6;
  logic [29:0] lz_exp;

  initial begin
    dash6 = pk(20, 20, 20, 20, 20, 20);
`ifdef SEG_LZ_BLANK_EN
    lz_exp = pk(31, 18, 0, 31, 31, 22);
`else
    lz_exp = pk(0, 18, 0, 31, 31, 22);
`endif

    // Reset state while rst_n is held low.
    exp_dis(2, dash6, "rst_dis");
    exp_bit(2, K_BUSY, 1'b0, "rst_busy");
    exp_bit(2, K_PAGE, 1'b0, "rst_page");
    while (cyc < 4) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    $display("txn reset released");

    // 1: no data, page toggles at 100/200/300.
    exp_dis(1, dash6, "t1_dis1");
    exp_bit(1, K_BUSY, 1'b0, "t1_busy");
    exp_dis(50, dash6, "t1_dis50");
    exp_dis(150, dash6, "t1_dis150");
    exp_dis(250, dash6, "t1_dis250");
    exp_dis(300, dash6, "t1_dis300");
    exp_bit(99, K_PAGE, 1'b0, "t1_pg99");
    exp_bit(100, K_PAGE, 1'b1, "t1_pg100");
    exp_bit(199, K_PAGE, 1'b1, "t1_pg199");
    exp_bit(200, K_PAGE, 1'b0, "t1_pg200");
    exp_bit(299, K_PAGE, 1'b0, "t1_pg299");
    exp_bit(300, K_PAGE, 1'b1, "t1_pg300");

    // 2: tem 25.6 / hum 60.0 at T=365, visible at 403 (page 0).
    exp_bit(364, K_BUSY, 1'b0, "t2_busy_pre");
    exp_bit(365, K_BUSY, 1'b1, "t2_busy_T");
    exp_bit(385, K_BUSY, 1'b1, "t2_busy_mid");
    exp_bit(401, K_BUSY, 1'b1, "t2_busy_last");
    exp_bit(402, K_BUSY, 1'b0, "t2_busy_end");
    exp_dis(402, dash6, "t2_dis_early");
    exp_dis(403, pk(2, 15, 6, 31, 31, 21), "t2_tem");
    exp_dis(500, pk(2, 15, 6, 31, 31, 21), "t2_tem_hold");
    exp_dis(501, pk(6, 10, 0, 31, 31, 22), "t2_hum");
    send(365, 25, 6, 60, 0, 1'b1, 1'b0);

    // 3: hum 8.0 on the humidity page (leading zero).
    exp_dis(547, pk(6, 10, 0, 31, 31, 22), "t3_old");
    exp_dis(548, lz_exp, "t3_hum_lz");
    exp_dis(601, pk(2, 15, 6, 31, 31, 21), "t3_tem");
    send(510, 25, 6, 8, 0, 1'b1, 1'b0);

    // 4: tem 120 with decimal byte 17, hum 45.3.
    exp_dis(647, pk(2, 15, 6, 31, 31, 21), "t4_old");
    exp_dis(648, pk(20, 20, 7, 31, 31, 21), "t4_tem_ovf");
    exp_dis(701, pk(4, 15, 3, 31, 31, 22), "t4_hum");
    send(610, 120, 17, 45, 3, 1'b1, 1'b0);

    // 5: error handling.
    exp_dis(710, pk(4, 15, 3, 31, 31, 22), "t5_pre_err");
    exp_dis(711, dash6, "t5_err");
    exp_bit(720, K_BUSY, 1'b0, "t5_same_busy");
    exp_bit(725, K_BUSY, 1'b0, "t5_same_busy2");
    exp_dis(758, dash6, "t5_same_dis");
    exp_dis(760, dash6, "t5_same_dis2");
    exp_bit(780, K_BUSY, 1'b1, "t5_err_busy");
    exp_bit(806, K_BUSY, 1'b1, "t5_busy_last");
    exp_bit(807, K_BUSY, 1'b0, "t5_busy_end");
    exp_dis(801, dash6, "t5_err_hold");
    exp_dis(807, dash6, "t5_pre_commit");
    exp_dis(808, pk(3, 13, 4, 31, 31, 21), "t5_recover");
    send(710, 0, 0, 0, 0, 1'b0, 1'b1);
    send(720, 11, 1, 22, 2, 1'b1, 1'b1);
    send(770, 33, 4, 55, 5, 1'b1, 1'b0);
    send(780, 77, 7, 77, 7, 1'b0, 1'b1);

    // 6a: second valid during conversion is dropped.
    exp_bit(830, K_BUSY, 1'b1, "t6_busy");
    exp_bit(857, K_BUSY, 1'b0, "t6_busy_end");
    exp_dis(857, pk(3, 13, 4, 31, 31, 21), "t6_old");
    exp_dis(858, pk(1, 19, 2, 31, 31, 21), "t6_tem");
    exp_dis(901, pk(3, 10, 1, 31, 31, 22), "t6_hum");
    // 6b: reset mid-conversion.
    exp_dis(929, dash6, "t6_rst_dis");
    exp_bit(929, K_BUSY, 1'b0, "t6_rst_busy");
    exp_bit(929, K_PAGE, 1'b0, "t6_rst_page");
    send(820, 19, 2, 30, 1, 1'b1, 1'b0);
    send(830, 99, 9, 99, 9, 1'b1, 1'b0);
    send(910, 12, 3, 45, 6, 1'b1, 1'b0);
    send(920, 98, 8, 97, 7, 1'b1, 1'b0);
    while (cyc < base + 928) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    $display("txn reset asserted mid-conversion");
    while (cyc < base + 935) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    $display("txn reset released");

    exp_dis(1, dash6, "t6_post_dis");
    exp_bit(1, K_PAGE, 1'b0, "t6_post_page");
    exp_bit(1, K_BUSY, 1'b0, "t6_post_busy");
    exp_dis(60, dash6, "t6_lost");
    exp_bit(60, K_BUSY, 1'b0, "t6_lost_busy");
    exp_bit(99, K_PAGE, 1'b0, "t6_pg99");
    exp_bit(100, K_PAGE, 1'b1, "t6_pg100");
    exp_dis(101, dash6, "t6_dis101");
    while (cyc < base + 105) @(negedge clk);
    @(negedge clk);

    if (exp_q.size() != 0) begin
      $display("FAIL pending: %0d expectations never checked, want 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
